// File: rtl/input_port_router_pkg.sv
// Shared definitions for the mesh router ingress path: field widths, direction
// encoding, packet layout and the XY dimension-order route function.
package input_port_router_pkg;

  localparam int NETWORK_ADDRESS_W    = 4;
  localparam int CACHE_BANK_ADDRESS_W = 8;
  localparam int DESTINATION_W        = NETWORK_ADDRESS_W + CACHE_BANK_ADDRESS_W;
  localparam int PACKET_DATA_W        = 32;
  localparam int NUM_DIRECTIONS       = 5;

  typedef enum logic [2:0] {
    DIR_NORTH = 3'd0,
    DIR_SOUTH = 3'd1,
    DIR_EAST  = 3'd2,
    DIR_WEST  = 3'd3,
    DIR_LOCAL = 3'd4
  } direction_e;

  typedef logic [NUM_DIRECTIONS-1:0] routeOneHot_t;

  typedef struct packed {
    logic [DESTINATION_W-1:0]     destination;
    logic [NETWORK_ADDRESS_W-1:0] requester;
    logic                         read;
    logic                         write;
    logic [PACKET_DATA_W-1:0]     data;
  } packet_t;

  typedef enum logic {
    OUT_EMPTY   = 1'b0,
    OUT_PRESENT = 1'b1
  } outState_e;

  function automatic routeOneHot_t dirOneHot(input direction_e dir);
    routeOneHot_t oneHot;
    oneHot      = '0;
    oneHot[dir] = 1'b1;
    return oneHot;
  endfunction

  // X is resolved before Y; coordinates arrive zero-extended so the compares stay unsigned.
  function automatic routeOneHot_t xyRoute(input logic [7:0] dx, input logic [7:0] dy,
                                           input logic [7:0] localX, input logic [7:0] localY);
    if (dx > localX)      return dirOneHot(DIR_EAST);
    else if (dx < localX) return dirOneHot(DIR_WEST);
    else if (dy > localY) return dirOneHot(DIR_SOUTH);
    else if (dy < localY) return dirOneHot(DIR_NORTH);
    else                  return dirOneHot(DIR_LOCAL);
  endfunction

endpackage

// File: rtl/input_port_router_fifo.sv
// Parameterised synchronous circular FIFO with occupancy count; storage is not
// reset, only the pointers and count are.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wrData,
  output logic [WIDTH-1:0]           rdData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop && !empty;
  // A simultaneous pop frees the slot being written, so push is legal at full.
  assign doPush = push && (!full || doPop);
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/input_port_router.sv
// Mesh router ingress port: buffers link packets, routes XY at write time and
// presents the head packet one-hot to the downstream consumers until accepted.
module input_port_router
  import input_port_router_pkg::*;
#(
  parameter int NETWORK_ADDRESS_WIDTH    = 4,
  parameter int CACHE_BANK_ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH               = 32,
  parameter int FIFO_DEPTH               = 4,
  parameter int LOCAL_X                  = 1,
  parameter int LOCAL_Y                  = 1
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                inValid,
  output logic                                                inReady,
  input  logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] inDestinationAddress,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]                    inRequesterAddress,
  input  logic                                                inRead,
  input  logic                                                inWrite,
  input  logic [DATA_WIDTH-1:0]                               inData,
  output logic                                                selectBit_NORTH,
  output logic                                                selectBit_SOUTH,
  output logic                                                selectBit_EAST,
  output logic                                                selectBit_WEST,
  output logic                                                selectBit_LOCAL,
  output logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressOut,
  output logic [NETWORK_ADDRESS_WIDTH-1:0]                    requesterAddressOut,
  output logic                                                readOut,
  output logic                                                writeOut,
  output logic [DATA_WIDTH-1:0]                               dataOut,
  input  logic                                                outAccept,
  output logic                                                dropPulse,
  output logic [7:0]                                          dropCount
);

  localparam int HALF_W  = NETWORK_ADDRESS_WIDTH / 2;
  localparam int DEST_W  = NETWORK_ADDRESS_WIDTH + CACHE_BANK_ADDRESS_WIDTH;
  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    routeOneHot_t                     route;
    logic [DEST_W-1:0]                destination;
    logic [NETWORK_ADDRESS_WIDTH-1:0] requester;
    logic                             read;
    logic                             write;
    logic [DATA_WIDTH-1:0]            data;
  } entry_t;

  function automatic logic [7:0] satIncrement(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  entry_t                           wrEntry_p0;
  entry_t                           headEntry;
  entry_t                           head_p1;
  logic [NETWORK_ADDRESS_WIDTH-1:0] destNode;
  logic                             accept;
  logic                             malformed;
  logic                             push_p0;
  logic                             fifoFull;
  logic                             fifoEmpty;
  logic [COUNT_W-1:0]               fifoCount;
  logic                             unusedFifoCount;
  logic                             loadHead;
  logic                             vld_p1;
  outState_e                        state;
  outState_e                        nextState;

  // Stage p0: link handshake, malformed filter and route computation at FIFO write.
  assign inReady   = !fifoFull;
  assign accept    = inValid && inReady;
  assign malformed = (inRead == inWrite);
  assign push_p0   = accept && !malformed;
  assign destNode  = inDestinationAddress[DEST_W-1 -: NETWORK_ADDRESS_WIDTH];

  always_comb begin
    wrEntry_p0.route       = xyRoute(8'(destNode[HALF_W-1:0]),
                                     8'(destNode[NETWORK_ADDRESS_WIDTH-1:HALF_W]),
                                     8'(LOCAL_X), 8'(LOCAL_Y));
    wrEntry_p0.destination = inDestinationAddress;
    wrEntry_p0.requester   = inRequesterAddress;
    wrEntry_p0.read        = inRead;
    wrEntry_p0.write       = inWrite;
    wrEntry_p0.data        = inData;
  end

  router_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) ingressFifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push_p0),
    .pop    (loadHead),
    .wrData (wrEntry_p0),
    .rdData (headEntry),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  assign unusedFifoCount = ^fifoCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      dropPulse <= 1'b0;
      dropCount <= 8'd0;
    end else begin
      dropPulse <= accept && malformed;
      if (accept && malformed) dropCount <= satIncrement(dropCount);
    end
  end

  // Stage p1: output register presented to the consumers.
  always_ff @(posedge clk) begin
    if (reset) state <= OUT_EMPTY;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    loadHead  = 1'b0;
    case (state)
      OUT_EMPTY: begin
        if (!fifoEmpty) begin
          loadHead  = 1'b1;
          nextState = OUT_PRESENT;
        end
      end
      OUT_PRESENT: begin
        if (outAccept) begin
          loadHead  = !fifoEmpty;
          nextState = fifoEmpty ? OUT_EMPTY : OUT_PRESENT;
        end
      end
      default: nextState = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (loadHead) head_p1 <= headEntry;
  end

  always_comb begin
    vld_p1                = (state == OUT_PRESENT);
    selectBit_NORTH       = vld_p1 && head_p1.route[DIR_NORTH];
    selectBit_SOUTH       = vld_p1 && head_p1.route[DIR_SOUTH];
    selectBit_EAST        = vld_p1 && head_p1.route[DIR_EAST];
    selectBit_WEST        = vld_p1 && head_p1.route[DIR_WEST];
    selectBit_LOCAL       = vld_p1 && head_p1.route[DIR_LOCAL];
    readOut               = vld_p1 && head_p1.read;
    writeOut              = vld_p1 && head_p1.write;
    destinationAddressOut = head_p1.destination;
    requesterAddressOut   = head_p1.requester;
    dataOut               = head_p1.data;
  end

endmodule

// File: tb/tb_input_port_router.sv
// Directed bench for input_port_router: table-driven route vectors plus
// hand-written sequences for back-to-back, backpressure, drops, reset and wrap.
module tb_input_port_router;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [11:0] inDestinationAddress;
  logic [3:0]  inRequesterAddress;
  logic        inRead;
  logic        inWrite;
  logic [31:0] inData;
  logic        selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST, selectBit_LOCAL;
  logic [11:0] destinationAddressOut;
  logic [3:0]  requesterAddressOut;
  logic        readOut;
  logic        writeOut;
  logic [31:0] dataOut;
  logic        outAccept;
  logic        dropPulse;
  logic [7:0]  dropCount;
  logic [4:0]  sel;

  localparam logic [4:0] SEL_N = 5'b00001;
  localparam logic [4:0] SEL_S = 5'b00010;
  localparam logic [4:0] SEL_E = 5'b00100;
  localparam logic [4:0] SEL_W = 5'b01000;
  localparam logic [4:0] SEL_L = 5'b10000;

  typedef struct {
    logic [3:0]  node;
    logic        rd;
    logic [31:0] data;
    logic [4:0]  expSel;
  } routeVec_t;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  assign sel = {selectBit_LOCAL, selectBit_WEST, selectBit_EAST, selectBit_SOUTH, selectBit_NORTH};

  input_port_router #(
    .NETWORK_ADDRESS_WIDTH(4), .CACHE_BANK_ADDRESS_WIDTH(8), .DATA_WIDTH(32),
    .FIFO_DEPTH(4), .LOCAL_X(1), .LOCAL_Y(1)
  ) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .inDestinationAddress(inDestinationAddress), .inRequesterAddress(inRequesterAddress),
    .inRead(inRead), .inWrite(inWrite), .inData(inData),
    .selectBit_NORTH(selectBit_NORTH), .selectBit_SOUTH(selectBit_SOUTH),
    .selectBit_EAST(selectBit_EAST), .selectBit_WEST(selectBit_WEST),
    .selectBit_LOCAL(selectBit_LOCAL),
    .destinationAddressOut(destinationAddressOut), .requesterAddressOut(requesterAddressOut),
    .readOut(readOut), .writeOut(writeOut), .dataOut(dataOut),
    .outAccept(outAccept), .dropPulse(dropPulse), .dropCount(dropCount)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendPkt(input logic [3:0] node, input logic rd, input logic wr, input logic [31:0] d);
    inValid              = 1'b1;
    inDestinationAddress = {node, d[7:0]};
    inRequesterAddress   = d[3:0] ^ 4'hA;
    inRead               = rd;
    inWrite              = wr;
    inData               = d;
  endtask

  task automatic idle();
    inValid = 1'b0;
    inRead  = 1'b0;
    inWrite = 1'b0;
  endtask

  task automatic checkHead(input string name, input logic [3:0] node, input logic rd,
                           input logic [31:0] d, input logic [4:0] expSel);
    check({name, "_sel"},   sel, expSel);
    check({name, "_dest"},  destinationAddressOut, {node, d[7:0]});
    check({name, "_req"},   requesterAddressOut, d[3:0] ^ 4'hA);
    check({name, "_read"},  readOut, rd);
    check({name, "_write"}, writeOut, !rd);
    check({name, "_data"},  dataOut, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    routeVec_t   vecs[8];
    logic [3:0]  b2bNodes[4];
    logic [4:0]  b2bSel[4];
    logic [31:0] expQ[$];
    int          sent;
    int          recv;

    vecs[0] = '{node: 4'b0111, rd: 1'b1, data: 32'hA000_0011, expSel: SEL_E};
    vecs[1] = '{node: 4'b0001, rd: 1'b0, data: 32'hA000_0022, expSel: SEL_N};
    vecs[2] = '{node: 4'b1001, rd: 1'b1, data: 32'hA000_0033, expSel: SEL_S};
    vecs[3] = '{node: 4'b0100, rd: 1'b0, data: 32'hA000_0044, expSel: SEL_W};
    vecs[4] = '{node: 4'b0101, rd: 1'b1, data: 32'hA000_0055, expSel: SEL_L};
    vecs[5] = '{node: 4'b1100, rd: 1'b1, data: 32'hA000_0066, expSel: SEL_W};
    vecs[6] = '{node: 4'b0010, rd: 1'b0, data: 32'hA000_0077, expSel: SEL_E};
    vecs[7] = '{node: 4'b1101, rd: 1'b1, data: 32'hA000_0088, expSel: SEL_S};

    idle();
    inDestinationAddress = '0;
    inRequesterAddress   = '0;
    inData               = '0;
    outAccept            = 1'b0;
    reset                = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("rst_inReady",   inReady, 1'b1);
    check("rst_sel",       sel, 5'b0);
    check("rst_readOut",   readOut, 1'b0);
    check("rst_writeOut",  writeOut, 1'b0);
    check("rst_dropPulse", dropPulse, 1'b0);
    check("rst_dropCount", dropCount, 8'd0);

    // Single packets: latency two edges, consumed on accept.
    for (int i = 0; i < 8; i++) begin
      outAccept = 1'b0;
      sendPkt(vecs[i].node, vecs[i].rd, !vecs[i].rd, vecs[i].data);
      tick();
      idle();
      check($sformatf("vec%0d_notyet", i), sel, 5'b0);
      tick();
      checkHead($sformatf("vec%0d", i), vecs[i].node, vecs[i].rd, vecs[i].data, vecs[i].expSel);
      outAccept = 1'b1;
      tick();
      outAccept = 1'b0;
      check($sformatf("vec%0d_gone", i), sel, 5'b0);
    end

    // Back-to-back with outAccept high: one packet per cycle, no bubbles.
    b2bNodes = '{4'b0001, 4'b1001, 4'b0100, 4'b0101};
    b2bSel   = '{SEL_N, SEL_S, SEL_W, SEL_L};
    outAccept = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sendPkt(b2bNodes[i], 1'b1, 1'b0, 32'h100 + i);
      tick();
      if (i > 0) checkHead($sformatf("b2b%0d", i-1), b2bNodes[i-1], 1'b1, 32'h100 + i - 1, b2bSel[i-1]);
    end
    idle();
    tick();
    checkHead("b2b3", b2bNodes[3], 1'b1, 32'h103, b2bSel[3]);
    tick();
    check("b2b_drained", sel, 5'b0);

    // Backpressure: capacity is FIFO plus output register.
    outAccept = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sendPkt(4'b0101, i[0], !i[0], 32'h200 + i);
      check($sformatf("bp_inReady%0d", i), inReady, (i < 5));
      tick();
    end
    idle();
    checkHead("bp_hold0", 4'b0101, 1'b0, 32'h200, SEL_L);
    tick();
    checkHead("bp_hold1", 4'b0101, 1'b0, 32'h200, SEL_L);
    outAccept = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checkHead($sformatf("bp_drain%0d", k), 4'b0101, k[0], 32'h200 + k, SEL_L);
      tick();
    end
    check("bp_empty", sel, 5'b0);
    outAccept = 1'b0;

    // Malformed packets are dropped and counted.
    sendPkt(4'b0111, 1'b1, 1'b1, 32'h300);
    tick();
    check("drop1_pulse", dropPulse, 1'b1);
    check("drop1_count", dropCount, 8'd1);
    sendPkt(4'b0111, 1'b0, 1'b0, 32'h301);
    tick();
    check("drop2_pulse", dropPulse, 1'b1);
    check("drop2_count", dropCount, 8'd2);
    check("drop2_sel",   sel, 5'b0);
    idle();
    tick();
    check("drop_pulse_end", dropPulse, 1'b0);
    check("drop_count_2",   dropCount, 8'd2);
    check("drop_sel_end",   sel, 5'b0);
    check("drop_inReady",   inReady, 1'b1);
    for (int i = 0; i < 300; i++) begin
      sendPkt(4'b0101, 1'b0, 1'b0, 32'h400 + i);
      tick();
    end
    idle();
    tick();
    check("drop_saturate", dropCount, 8'd255);
    check("drop_sat_sel",  sel, 5'b0);

    // Reset with one packet presented and three buffered.
    outAccept = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sendPkt(4'b0101, 1'b1, 1'b0, 32'h500 + i);
      tick();
    end
    idle();
    check("prerst_sel", sel, SEL_L);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_sel",       sel, 5'b0);
    check("midrst_inReady",   inReady, 1'b1);
    check("midrst_readOut",   readOut, 1'b0);
    check("midrst_dropCount", dropCount, 8'd0);
    outAccept = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("midrst_stale%0d", i), sel, 5'b0);
    end

    // Sustained streaming from full with pointer wrap; scoreboard checks order.
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      outAccept = (cyc >= 5);
      if (sent < 25) sendPkt(4'b0111, 1'b1, 1'b0, 32'h600 + sent);
      else           idle();
      if (cyc == 5) check("wrap_full_inReady", inReady, 1'b0);
      if (inValid && inReady) begin
        expQ.push_back(32'h600 + sent);
        sent++;
      end
      if (outAccept && sel != 5'b0) begin
        if (expQ.size() == 0) begin
          check("wrap_unexpected", dataOut, 32'hFFFF_FFFF);
        end else begin
          check($sformatf("wrap_data%0d", recv), dataOut, expQ.pop_front());
          recv++;
        end
      end
      check($sformatf("wrap_occ%0d", cyc), (dut.ingressFifo.count <= 4), 1'b1);
      tick();
    end
    idle();
    check("wrap_sent",  sent, 25);
    check("wrap_recv",  recv, 25);
    check("wrap_left",  expQ.size(), 0);
    check("wrap_empty", sel, 5'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
